// File: rtl/controlador_estados_param.sv
// Parametrised pet-state controller: a free-running divider paces decisions that
// move the pet between idle, action and dead states from latched button presses and stat levels.
module controlador_estados_param #(
  parameter int TICK_W      = 16,
  parameter int N_STATS     = 3,
  parameter int STAT_W      = 8,
  parameter int LIMIAR      = 0,
  parameter int ACT_TICKS   = 8,
  parameter int RESET_TICKS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        b1,
  input  logic                        b2,
  input  logic [N_STATS*STAT_W-1:0]   stats,
  output logic [3:0]                  estado,
  output logic                        tick,
  output logic                        mudou
);

  localparam int ACT_W = (ACT_TICKS > 0) ? $clog2(ACT_TICKS + 1) : 1;
  localparam int REV_W = (RESET_TICKS > 0) ? $clog2(RESET_TICKS + 1) : 1;
  localparam logic [ACT_W:0]    ACT_LIM = (ACT_W + 1)'(ACT_TICKS);
  localparam logic [REV_W:0]    REV_LIM = (REV_W + 1)'(RESET_TICKS);
  localparam logic [STAT_W-1:0] LIM_V   = STAT_W'(LIMIAR);
  localparam bit ACT_EN = (ACT_TICKS != 0);
  localparam bit REV_EN = (RESET_TICKS != 0);

  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [TICK_W-1:0] counter_q, counter_d;
  logic              b1_lat_q, b1_lat_d;
  logic              b2_lat_q, b2_lat_d;
  logic [ACT_W-1:0]  act_cnt_q, act_cnt_d;
  logic [REV_W-1:0]  rev_cnt_q, rev_cnt_d;
  logic              tick_q, tick_d;
  logic              mudou_q, mudou_d;
  logic              decision;
  logic              fatal;

  // The decision edge is the one that wraps the divider back to zero.
  always_comb begin
    counter_d = counter_q + 1'b1;
    decision  = (counter_q == {TICK_W{1'b1}});
    fatal     = 1'b0;
    for (int i = 0; i < N_STATS; i++) begin
      if (stats[i*STAT_W +: STAT_W] <= LIM_V) fatal = 1'b1;
    end
    if (decision) begin
      b1_lat_d = b1;
      b2_lat_d = b2;
    end else begin
      b1_lat_d = b1_lat_q | b1;
      b2_lat_d = b2_lat_q | b2;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    act_cnt_d = act_cnt_q;
    rev_cnt_d = rev_cnt_q;
    if (decision) begin
      if (estado_q == MORTO) begin
        if (REV_EN && b1_lat_q && b2_lat_q && !fatal) begin
          if (({1'b0, rev_cnt_q} + 1'b1) == REV_LIM) begin
            estado_d  = IDLE;
            rev_cnt_d = '0;
          end else if (rev_cnt_q != {REV_W{1'b1}}) begin
            rev_cnt_d = rev_cnt_q + 1'b1;
          end
        end else begin
          rev_cnt_d = '0;
        end
      end else if (fatal) begin
        estado_d  = MORTO;
        rev_cnt_d = '0;
      end else begin
        case (estado_q)
          IDLE: begin
            act_cnt_d = '0;
            if (b1_lat_q && b2_lat_q)  estado_d = DANDO_AULA;
            else if (b1_lat_q)         estado_d = COMENDO;
            else if (b2_lat_q)         estado_d = DORMINDO;
          end
          DORMINDO, COMENDO, DANDO_AULA: begin
            if (b1_lat_q || b2_lat_q) begin
              estado_d = IDLE;
            end else if (ACT_EN && (({1'b0, act_cnt_q} + 1'b1) == ACT_LIM)) begin
              estado_d = IDLE;
            end else if (act_cnt_q != {ACT_W{1'b1}}) begin
              act_cnt_d = act_cnt_q + 1'b1;
            end
          end
          default: estado_d = IDLE;
        endcase
      end
    end
    tick_d  = decision;
    mudou_d = decision && (estado_d != estado_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= IDLE;
      counter_q <= {{(TICK_W-1){1'b0}}, 1'b1};
      b1_lat_q  <= 1'b0;
      b2_lat_q  <= 1'b0;
      act_cnt_q <= '0;
      rev_cnt_q <= '0;
      tick_q    <= 1'b0;
      mudou_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      counter_q <= counter_d;
      b1_lat_q  <= b1_lat_d;
      b2_lat_q  <= b2_lat_d;
      act_cnt_q <= act_cnt_d;
      rev_cnt_q <= rev_cnt_d;
      tick_q    <= tick_d;
      mudou_q   <= mudou_d;
    end
  end

  assign estado = estado_q;
  assign tick   = tick_q;
  assign mudou  = mudou_q;

endmodule
